// File: rtl/ibr128_feeder.sv
// Packs 32-bit upstream words into 128-bit blocks, queues up to two completed blocks,
// and issues them one at a time to a block cipher core with a start strobe and first-block flag.
module ibr128_feeder (
  input  logic         Clk,
  input  logic         RstN,
  input  logic         in_valid,
  input  logic [31:0]  in_data,
  input  logic         in_first,
  output logic         in_ready,
  input  logic         flush,
  output logic [127:0] plainText,
  output logic         SA,
  output logic         FB,
  output logic         Enable,
  input  logic         cipherReady,
  output logic         busy,
  output logic [15:0]  block_count
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e         state_q, state_d;
  logic [1:0]     wcnt_q;
  logic [95:0]    part_q;
  logic           first_q;
  logic [128:0]   fifo_q [2];
  logic           rd_ptr_q, wr_ptr_q;
  logic [1:0]     count_q, count_d;
  logic [127:0]   pt_q;
  logic           fb_q;
  logic [15:0]    bcnt_q;

  logic           transfer, push, pop, load;
  logic [128:0]   new_entry, head;

  assign pop       = (state_q == StIssue);
  assign transfer  = in_valid && in_ready;
  assign push      = transfer && (wcnt_q == 2'd3) && !flush;
  assign new_entry = {first_q, part_q, in_data};
  // With an empty FIFO the block being pushed this edge is the head, which gives
  // single-cycle latency from word 3 to the start strobe.
  assign head      = (count_q != 2'd0) ? fifo_q[rd_ptr_q] : new_entry;
  assign load      = (state_q == StIdle) && (state_d == StIssue);

  // Word assembly
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      wcnt_q  <= 2'd0;
      part_q  <= 96'd0;
      first_q <= 1'b0;
    end else if (flush) begin
      wcnt_q  <= 2'd0;
    end else if (transfer) begin
      wcnt_q <= wcnt_q + 2'd1;
      unique case (wcnt_q)
        2'd0: begin
          part_q[95:64] <= in_data;
          first_q       <= in_first;
        end
        2'd1:    part_q[63:32] <= in_data;
        2'd2:    part_q[31:0]  <= in_data;
        default: ;
      endcase
    end
  end

  // Block FIFO
  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (flush) begin
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      count_q <= count_d;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) fifo_q[wr_ptr_q] <= new_entry;
  end

  // Issue FSM: state register
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Issue FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!flush && (count_q != 2'd0 || push)) state_d = StIssue;
      StIssue: state_d = StWait;
      StWait:  if (cipherReady) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Block register, tag and issue counter are captured on entry to issue
  always_ff @(posedge Clk or negedge RstN) begin
    if (!RstN) begin
      pt_q   <= 128'd0;
      fb_q   <= 1'b0;
      bcnt_q <= 16'd0;
    end else if (load) begin
      pt_q   <= head[127:0];
      fb_q   <= head[128];
      bcnt_q <= bcnt_q + 16'd1;
    end
  end

  // Issue FSM: outputs
  always_comb begin
    SA       = (state_q == StIssue);
    FB       = (state_q == StIssue) && fb_q;
    Enable   = (state_q != StIdle);
    busy     = (state_q != StIdle) || (count_q != 2'd0);
    in_ready = !((wcnt_q == 2'd3) && (count_q == 2'd2) && !pop);
  end

  assign plainText   = pt_q;
  assign block_count = bcnt_q;

endmodule
